// File: rtl/pal.sv
// Serially programmed PAL macro: AND plane of P product terms feeding an OR plane of M outputs.
// The fuse map is the only state; outputs are a purely combinational function of inputs and map.
module pal #(
    parameter int N = 4,
    parameter int M = 3,
    parameter int P = 3
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         CFG,
    input  logic [N-1:0] INPUT_VARS,
    output logic [M-1:0] OUTPUT_VALS
);

    localparam int L     = 2 * N * P + P * M;
    localparam int OR_LO = 2 * N * P;

    logic [L-1:0]   r_cfg;
    logic [2*N-1:0] w_lits;
    logic [P-1:0]   w_terms;

    // Every edge shifts; the host pauses loading by stopping the clock.
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking so every reader sees the pre-edge chain contents.
        if (RST) begin
            r_cfg <= '0;
        end else begin
            r_cfg <= {r_cfg[L-2:0], CFG};
        end
    end

    // Literal pairs interleave as {~x[i], x[i]} to match the fuse layout of each term.
    for (genvar i = 0; i < N; i++) begin : g_lits
        assign w_lits[2*i]     = INPUT_VARS[i];
        assign w_lits[2*i + 1] = ~INPUT_VARS[i];
    end

    // A term with no fuse blown is forced low so unused terms cannot assert outputs.
    for (genvar p = 0; p < P; p++) begin : g_and_plane
        logic [2*N-1:0] w_fuse;
        assign w_fuse     = r_cfg[2*N*p +: 2*N];
        assign w_terms[p] = (|w_fuse) & (&(w_lits | ~w_fuse));
    end

    for (genvar m = 0; m < M; m++) begin : g_or_plane
        assign OUTPUT_VALS[m] = |(w_terms & r_cfg[OR_LO + P*m +: P]);
    end

endmodule

// File: tb/tb_pal.sv
// Directed bench for pal: expectations are queued as stimulus is applied, then drained
// against the DUT outputs or the configuration chain.
module tb_pal;

    localparam int N = 4;
    localparam int M = 3;
    localparam int P = 3;
    localparam int L = 2 * N * P + P * M;

    typedef struct {
        string        tag;
        bit           is_cfg;
        logic [L-1:0] exp;
    } exp_t;

    logic         CLK;
    logic         RST;
    logic         CFG;
    logic [N-1:0] INPUT_VARS;
    logic [M-1:0] OUTPUT_VALS;

    exp_t sb[$];
    int   vectors;
    int   miscompares;

    pal #(.N(N), .M(M), .P(P)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .CFG        (CFG),
        .INPUT_VARS (INPUT_VARS),
        .OUTPUT_VALS(OUTPUT_VALS)
    );

    task automatic tick();
        #5 CLK = 1'b1;
        #5 CLK = 1'b0;
    endtask

    task automatic compare_pending();
        exp_t         e;
        logic [L-1:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = e.is_cfg ? dut.r_cfg : L'(OUTPUT_VALS);
            vectors++;
            assert (obs === e.exp) else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic drive_in(input logic [N-1:0] x, input logic [M-1:0] exp, input string tag);
        exp_t e;
        INPUT_VARS = x;
        e.tag      = tag;
        e.is_cfg   = 1'b0;
        e.exp      = L'(exp);
        sb.push_back(e);
        #1;
        compare_pending();
    endtask

    task automatic expect_cfg(input logic [L-1:0] exp, input string tag);
        exp_t e;
        e.tag    = tag;
        e.is_cfg = 1'b1;
        e.exp    = exp;
        sb.push_back(e);
        #1;
        compare_pending();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    // MSB of the map goes in first so it ends up at cfg[L-1].
    task automatic load_map(input logic [L-1:0] map);
        for (int b = L - 1; b >= 0; b--) begin
            CFG = map[b];
            tick();
        end
    endtask

    initial begin
        logic [L-1:0] single_map;
        logic [L-1:0] sop_map;
        logic [L-1:0] ones;
        logic [L-1:0] top_bit;
        logic [N-1:0] x;
        logic         t0;
        logic         t1;

        CLK         = 1'b0;
        RST         = 1'b0;
        CFG         = 1'b0;
        INPUT_VARS  = '0;
        vectors     = 0;
        miscompares = 0;

        // t0 = x0 & ~x1 ; y0 = t0
        single_map     = '0;
        single_map[0]  = 1'b1;
        single_map[3]  = 1'b1;
        single_map[24] = 1'b1;

        // t0 = x0 & x1 ; t1 = ~x2 & x3 ; y1 = t0 | t1 ; y2 = t1
        sop_map     = '0;
        sop_map[0]  = 1'b1;
        sop_map[2]  = 1'b1;
        sop_map[13] = 1'b1;
        sop_map[14] = 1'b1;
        sop_map[27] = 1'b1;
        sop_map[28] = 1'b1;
        sop_map[31] = 1'b1;

        ones        = '1;
        top_bit     = '0;
        top_bit[32] = 1'b1;

        // Reset clears everything
        do_reset();
        expect_cfg('0, "reset_cfg");
        for (int v = 0; v < 16; v++) drive_in(N'(v), 3'b000, "reset_sweep");

        // All-ones map: every term holds x & ~x
        CFG = 1'b1;
        for (int k = 0; k < L; k++) tick();
        expect_cfg(ones, "ones_cfg");
        drive_in(4'b1111, 3'b000, "ones_1111");
        drive_in(4'b0000, 3'b000, "ones_0000");
        drive_in(4'b1111, 3'b000, "ones_1111b");
        for (int k = 0; k < 110; k++) tick();
        expect_cfg(ones, "ones_overrun_cfg");
        drive_in(4'b0101, 3'b000, "ones_overrun_0101");
        drive_in(4'b1010, 3'b000, "ones_overrun_1010");

        // Single product term
        do_reset();
        load_map(single_map);
        expect_cfg(single_map, "single_cfg");
        drive_in(4'b0001, 3'b001, "single_0001");
        drive_in(4'b0011, 3'b000, "single_0011");
        drive_in(4'b0000, 3'b000, "single_0000");

        // Sum of products with a shared term
        do_reset();
        load_map(sop_map);
        expect_cfg(sop_map, "sop_cfg");
        drive_in(4'b0011, 3'b010, "sop_0011");
        drive_in(4'b1000, 3'b110, "sop_1000");
        drive_in(4'b0111, 3'b010, "sop_0111");
        drive_in(4'b0100, 3'b000, "sop_0100");
        for (int v = 0; v < 16; v++) begin
            x  = N'(v);
            t0 = x[0] & x[1];
            t1 = ~x[2] & x[3];
            drive_in(x, {t1, t0 | t1, 1'b0}, "sop_sweep");
        end

        // Chain ordering and overflow of the top bit
        do_reset();
        CFG = 1'b1;
        tick();
        CFG = 1'b0;
        for (int k = 0; k < L - 1; k++) tick();
        expect_cfg(top_bit, "order_top_cfg");
        drive_in(4'b1111, 3'b000, "order_1111");
        drive_in(4'b0000, 3'b000, "order_0000");
        tick();
        expect_cfg('0, "overflow_cfg");

        // Reset in the middle of a load, with CFG high
        do_reset();
        for (int b = L - 1; b >= L - 20; b--) begin
            CFG = single_map[b];
            INPUT_VARS = N'(b);
            tick();
        end
        RST = 1'b1;
        CFG = 1'b1;
        tick();
        RST = 1'b0;
        expect_cfg('0, "midreset_cfg");
        drive_in(4'b0001, 3'b000, "midreset_0001");
        drive_in(4'b1111, 3'b000, "midreset_1111");
        load_map(single_map);
        expect_cfg(single_map, "reload_cfg");
        drive_in(4'b0001, 3'b001, "reload_0001");
        drive_in(4'b0011, 3'b000, "reload_0011");
        drive_in(4'b0000, 3'b000, "reload_0000");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
